// File: rtl/ula_iterativa.sv
// Iterative 32-bit ALU: add/sub/slt in one cycle, shift-add multiply and
// restoring divide over WIDTH cycles into HI/LO, with a start/busy/done handshake.
module ula_iterativa #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       ALUCon,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             zero,
    output logic             overflow,
    output logic             div_zero,
    output logic             busy,
    output logic             done
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t           state_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] work_hi_q;
    logic [WIDTH-1:0] work_lo_q;

    logic [WIDTH-1:0] sum_s;
    logic [WIDTH-1:0] diff_s;
    logic [WIDTH-1:0] fast_res_d;
    logic             fast_ovf_d;
    logic [WIDTH:0]   mul_sum_s;
    logic [WIDTH-1:0] mul_hi_d;
    logic [WIDTH-1:0] mul_lo_d;
    logic [WIDTH:0]   rem_sh_s;
    logic [WIDTH:0]   rem_sub_s;
    logic [WIDTH-1:0] div_hi_d;
    logic [WIDTH-1:0] div_lo_d;
    logic             last_s;

    // Single-cycle results computed from the live operands at the start edge.
    always_comb begin
        sum_s      = a + b;
        diff_s     = a - b;
        fast_res_d = {WIDTH{1'b0}};
        fast_ovf_d = 1'b0;
        case (ALUCon)
            3'b000: begin
                fast_res_d = sum_s;
                fast_ovf_d = (a[WIDTH-1] == b[WIDTH-1]) && (sum_s[WIDTH-1] != a[WIDTH-1]);
            end
            3'b001: begin
                fast_res_d = diff_s;
                fast_ovf_d = (a[WIDTH-1] != b[WIDTH-1]) && (diff_s[WIDTH-1] != a[WIDTH-1]);
            end
            3'b100: begin
                fast_res_d = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            end
            default: begin
                fast_res_d = {WIDTH{1'b0}};
            end
        endcase
    end

    // One multiply step: add multiplicand when the multiplier LSB is set, then
    // shift the 65-bit {carry, hi, lo} right by one.
    always_comb begin
        mul_sum_s = {1'b0, work_hi_q} + (work_lo_q[0] ? {1'b0, a_q} : {(WIDTH+1){1'b0}});
        mul_hi_d  = mul_sum_s[WIDTH:1];
        mul_lo_d  = {mul_sum_s[0], work_lo_q[WIDTH-1:1]};
    end

    // One restoring-division step; bit WIDTH of the trial subtraction is the borrow.
    always_comb begin
        rem_sh_s  = {work_hi_q, work_lo_q[WIDTH-1]};
        rem_sub_s = rem_sh_s - {1'b0, b_q};
        if (rem_sub_s[WIDTH]) begin
            div_hi_d = rem_sh_s[WIDTH-1:0];
        end else begin
            div_hi_d = rem_sub_s[WIDTH-1:0];
        end
        div_lo_d = {work_lo_q[WIDTH-2:0], ~rem_sub_s[WIDTH]};
    end

    assign last_s = (cnt_q == CW'(WIDTH - 1));

    // Control FSM with all outputs registered.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= {CW{1'b0}};
            a_q       <= {WIDTH{1'b0}};
            b_q       <= {WIDTH{1'b0}};
            work_hi_q <= {WIDTH{1'b0}};
            work_lo_q <= {WIDTH{1'b0}};
            result    <= {WIDTH{1'b0}};
            hi        <= {WIDTH{1'b0}};
            lo        <= {WIDTH{1'b0}};
            zero      <= 1'b0;
            overflow  <= 1'b0;
            div_zero  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_q   <= a;
                        b_q   <= b;
                        cnt_q <= {CW{1'b0}};
                        case (ALUCon)
                            3'b010: begin
                                work_hi_q <= {WIDTH{1'b0}};
                                work_lo_q <= b;
                                busy      <= 1'b1;
                                state_q   <= MUL;
                            end
                            3'b011: begin
                                if (b != {WIDTH{1'b0}}) begin
                                    work_hi_q <= {WIDTH{1'b0}};
                                    work_lo_q <= a;
                                    busy      <= 1'b1;
                                    state_q   <= DIV;
                                end else begin
                                    lo       <= {WIDTH{1'b1}};
                                    hi       <= a;
                                    result   <= {WIDTH{1'b1}};
                                    zero     <= 1'b0;
                                    overflow <= 1'b0;
                                    div_zero <= 1'b1;
                                    done     <= 1'b1;
                                    state_q  <= DONE;
                                end
                            end
                            default: begin
                                result   <= fast_res_d;
                                zero     <= (fast_res_d == {WIDTH{1'b0}});
                                overflow <= fast_ovf_d;
                                done     <= 1'b1;
                                state_q  <= DONE;
                            end
                        endcase
                    end
                end
                MUL: begin
                    work_hi_q <= mul_hi_d;
                    work_lo_q <= mul_lo_d;
                    cnt_q     <= cnt_q + CW'(1);
                    if (last_s) begin
                        hi       <= mul_hi_d;
                        lo       <= mul_lo_d;
                        result   <= mul_lo_d;
                        zero     <= (mul_lo_d == {WIDTH{1'b0}});
                        overflow <= 1'b0;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        state_q  <= DONE;
                    end
                end
                DIV: begin
                    work_hi_q <= div_hi_d;
                    work_lo_q <= div_lo_d;
                    cnt_q     <= cnt_q + CW'(1);
                    if (last_s) begin
                        hi       <= div_hi_d;
                        lo       <= div_lo_d;
                        result   <= div_lo_d;
                        zero     <= (div_lo_d == {WIDTH{1'b0}});
                        overflow <= 1'b0;
                        div_zero <= 1'b0;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        state_q  <= DONE;
                    end
                end
                DONE: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ula_iterativa.sv
// Self-checking bench for ula_iterativa: expected results are queued at issue
// time by a behavioural model and compared when done pulses.
module tb_ula_iterativa;

    localparam int W = 32;

    logic         clock = 1'b0;
    logic         reset;
    logic         start;
    logic [2:0]   ALUCon;
    logic [W-1:0] a, b, result, hi, lo;
    logic         zero, overflow, div_zero, busy, done;

    typedef struct packed {
        logic [W-1:0] result;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         zero;
        logic         ovf;
        logic         dz;
    } res_t;

    typedef struct {
        res_t r;
        int   lat;
    } exp_t;

    exp_t         sb[$];
    int           n_checks = 0;
    int           n_pass   = 0;
    logic [W-1:0] m_hi = '0;
    logic [W-1:0] m_lo = '0;
    logic         m_dz = 1'b0;

    ula_iterativa #(.WIDTH(W)) dut (
        .clock(clock), .reset(reset), .start(start), .ALUCon(ALUCon),
        .a(a), .b(b), .result(result), .hi(hi), .lo(lo), .zero(zero),
        .overflow(overflow), .div_zero(div_zero), .busy(busy), .done(done)
    );

    always #5 clock = ~clock;

    task automatic predict(input logic [2:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
        exp_t         e;
        logic [W-1:0] r;
        logic         v;
        logic [2*W-1:0] p;
        v = 1'b0;
        e.lat = 1;
        case (op)
            3'd0: begin r = x + y; v = (x[W-1] == y[W-1]) && (r[W-1] != x[W-1]); end
            3'd1: begin r = x - y; v = (x[W-1] != y[W-1]) && (r[W-1] != x[W-1]); end
            3'd2: begin
                p = {{W{1'b0}}, x} * {{W{1'b0}}, y};
                m_hi = p[2*W-1:W]; m_lo = p[W-1:0]; r = m_lo; e.lat = W + 1;
            end
            3'd3: begin
                if (y == '0) begin
                    m_lo = '1; m_hi = x; m_dz = 1'b1;
                end else begin
                    m_lo = x / y; m_hi = x % y; m_dz = 1'b0; e.lat = W + 1;
                end
                r = m_lo;
            end
            3'd4: r = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
            default: r = '0;
        endcase
        e.r.result = r;
        e.r.hi     = m_hi;
        e.r.lo     = m_lo;
        e.r.zero   = (r == '0);
        e.r.ovf    = v;
        e.r.dz     = m_dz;
        sb.push_back(e);
    endtask

    // Issue one operation, scramble inputs while it runs, and capture outputs at done.
    task automatic run_op(input logic [2:0] op, input logic [W-1:0] x, input logic [W-1:0] y,
                          input bit poke, output res_t o, output int lat,
                          output bit busy_err, output bit extra_done);
        int expl;
        @(negedge clock);
        start = 1'b1; ALUCon = op; a = x; b = y;
        predict(op, x, y);
        expl = sb[$].lat;
        lat = 0; busy_err = 1'b0; extra_done = 1'b0;
        do begin
            @(negedge clock);
            lat++;
            start  = (poke && (lat == 5 || lat == 20)) ? 1'b1 : 1'b0;
            a      = $urandom;
            b      = $urandom;
            ALUCon = 3'($urandom_range(0, 7));
            if (done !== 1'b1 && busy !== (expl > 1)) busy_err = 1'b1;
        end while (done !== 1'b1 && lat < 100);
        if (busy !== 1'b0) busy_err = 1'b1;
        o.result = result; o.hi = hi; o.lo = lo;
        o.zero = zero; o.ovf = overflow; o.dz = div_zero;
        start = poke;
        @(negedge clock);
        start = 1'b0;
        if (busy !== 1'b0 || done !== 1'b0) extra_done = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b1; ALUCon = 3'd0; a = 32'd5; b = 32'd7;
        repeat (3) @(posedge clock);
        @(negedge clock);
        n_checks++;
        if ({result, hi, lo, zero, overflow, div_zero, busy, done} !== '0)
            $display("FAIL reset_outputs got r=%h hi=%h lo=%h z=%b v=%b dz=%b busy=%b done=%b want all 0",
                     result, hi, lo, zero, overflow, div_zero, busy, done);
        else n_pass++;
        reset = 1'b0; start = 1'b0;
        repeat (2) @(negedge clock);
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b0)
            $display("FAIL reset_start_discard got done=%b busy=%b want 0 0", done, busy);
        else n_pass++;
    endtask

    task automatic test_single();
        logic [2:0]   ops[9] = '{3'd0, 3'd1, 3'd1, 3'd4, 3'd4, 3'd0, 3'd5, 3'd6, 3'd7};
        logic [W-1:0] xs[9]  = '{32'd5, 32'h7FFFFFFF, 32'd3, 32'hFFFFFFFE, 32'd1, 32'h7FFFFFFF, 32'd9, 32'd1, 32'd2};
        logic [W-1:0] ys[9]  = '{32'd7, 32'hFFFFFFFF, 32'd3, 32'd1, 32'hFFFFFFFE, 32'd1, 32'd9, 32'd1, 32'd3};
        res_t o; int lat; bit be, ed; exp_t e;
        for (int i = 0; i < 9; i++) begin
            run_op(ops[i], xs[i], ys[i], 1'b0, o, lat, be, ed);
            e = sb.pop_front();
            n_checks++;
            if (o !== e.r) $display("FAIL single%0d_outputs got=%h want=%h", i, o, e.r); else n_pass++;
            n_checks++;
            if (lat != e.lat) $display("FAIL single%0d_latency got=%0d want=%0d", i, lat, e.lat); else n_pass++;
            n_checks++;
            if (be || ed) $display("FAIL single%0d_handshake got busy_err=%b extra=%b want 0 0", i, be, ed); else n_pass++;
        end
    endtask

    task automatic test_mult();
        res_t o; int lat; bit be, ed; exp_t e;
        run_op(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, o, lat, be, ed);
        e = sb.pop_front();
        n_checks++;
        if (o !== e.r) $display("FAIL mult_outputs got=%h want=%h", o, e.r); else n_pass++;
        n_checks++;
        if (o.hi !== 32'hFFFFFFFE || o.lo !== 32'h00000001 || o.result !== 32'h00000001)
            $display("FAIL mult_const got hi=%h lo=%h r=%h want FFFFFFFE 00000001 00000001", o.hi, o.lo, o.result);
        else n_pass++;
        n_checks++;
        if (lat != 33) $display("FAIL mult_latency got=%0d want=33", lat); else n_pass++;
        n_checks++;
        if (be || ed) $display("FAIL mult_handshake got busy_err=%b extra=%b want 0 0", be, ed); else n_pass++;
        run_op(3'd0, 32'd10, 32'd20, 1'b0, o, lat, be, ed);
        e = sb.pop_front();
        n_checks++;
        if (o !== e.r) $display("FAIL add_after_mult got=%h want=%h", o, e.r); else n_pass++;
    endtask

    task automatic test_div();
        logic [W-1:0] xs[3] = '{32'd100, 32'd9, 32'hDEADBEEF};
        logic [W-1:0] ys[3] = '{32'd7, 32'd0, 32'd1234};
        res_t o; int lat; bit be, ed; exp_t e;
        for (int i = 0; i < 3; i++) begin
            run_op(3'd3, xs[i], ys[i], 1'b1, o, lat, be, ed);
            e = sb.pop_front();
            n_checks++;
            if (o !== e.r) $display("FAIL div%0d_outputs got=%h want=%h", i, o, e.r); else n_pass++;
            n_checks++;
            if (lat != e.lat) $display("FAIL div%0d_latency got=%0d want=%0d", i, lat, e.lat); else n_pass++;
            n_checks++;
            if (be || ed) $display("FAIL div%0d_handshake got busy_err=%b extra=%b want 0 0", i, be, ed); else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        res_t o; int lat; bit be, ed; exp_t e; bit stray;
        @(negedge clock);
        start = 1'b1; ALUCon = 3'd2; a = 32'hFFFFFFFF; b = 32'hFFFFFFFF;
        predict(3'd2, a, b);
        @(negedge clock);
        start = 1'b0;
        repeat (9) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        n_checks++;
        if ({result, hi, lo, zero, overflow, div_zero, busy, done} !== '0)
            $display("FAIL midreset_outputs got r=%h hi=%h lo=%h z=%b v=%b dz=%b busy=%b done=%b want all 0",
                     result, hi, lo, zero, overflow, div_zero, busy, done);
        else n_pass++;
        reset = 1'b0;
        void'(sb.pop_back());
        m_hi = '0; m_lo = '0; m_dz = 1'b0;
        stray = 1'b0;
        repeat (40) begin
            @(negedge clock);
            if (done !== 1'b0 || busy !== 1'b0) stray = 1'b1;
        end
        n_checks++;
        if (stray) $display("FAIL midreset_no_done got stray done/busy=1 want 0"); else n_pass++;
        run_op(3'd0, 32'd1, 32'd1, 1'b0, o, lat, be, ed);
        e = sb.pop_front();
        n_checks++;
        if (o !== e.r || o.result !== 32'd2) $display("FAIL midreset_add got=%h want=%h", o, e.r); else n_pass++;
    endtask

    task automatic test_back_to_back();
        res_t o; int lat; bit be, ed; exp_t e;
        logic [2:0] op;
        for (int i = 0; i < 8; i++) begin
            op = 3'($urandom_range(0, 7));
            run_op(op, $urandom, (i == 3) ? 32'd0 : $urandom, 1'b0, o, lat, be, ed);
            e = sb.pop_front();
            n_checks++;
            if (o !== e.r || lat != e.lat || be || ed)
                $display("FAIL b2b%0d op=%0d got=%h lat=%0d be=%b ed=%b want=%h lat=%0d",
                         i, op, o, lat, be, ed, e.r, e.lat);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_mult();
        test_div();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
